// File: rtl/gemm_wb_pkg.sv
// Shared types and helpers for the GeMM C-tile writeback stage.
package gemm_wb_pkg;

   typedef enum logic [0:0] {
      WB_IDLE = 1'b0,
      WB_SEND = 1'b1
   } wb_state_e;

   // Number of memory beats needed to drain one M x N tile.
   function automatic int beats_per_tile(input int m, input int n, input int beat_elems);
      return (m * n) / beat_elems;
   endfunction

endpackage

// File: rtl/gemm_tile_fifo.sv
// Generic synchronous FIFO holding whole C tiles (address + payload).
// The head entry is read straight from the storage registers, so rdata
// only changes when the head is popped or when an empty FIFO is written.
module gemm_tile_fifo #(
   parameter int Width = 8,
   parameter int Depth = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push,
   input  logic                         pop,
   input  logic [Width-1:0]             wdata,
   output logic [Width-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(Depth+1)-1:0]   count
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CntFull);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + PtrW'(1);
   endfunction

   // Pointer and occupancy bookkeeping; a push blocked by full is simply ignored here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
         if (push_ok && !pop_ok)      count_q <= count_q + CntOne;
         else if (!push_ok && pop_ok) count_q <= count_q - CntOne;
      end
   end

   // Payload storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/gemm_c_writeback.sv
// GeMM C-tile writeback: queues finished tiles and streams them out as
// narrow valid/ready memory beats.
// Optional build macro GEMM_WB_PERF_EN adds stall / tile-done counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   WB_IDLE | tile FIFO empty, no beat offered
//   WB_SEND | head tile being serialised, beat beat_idx offered on mem port
module gemm_c_writeback
   import gemm_wb_pkg::*;
#(
   parameter int OutDataWidth = 32,
   parameter int M            = 4,
   parameter int N            = 4,
   parameter int AddrWidth    = 16,
   parameter int BeatElems    = 4,
   parameter int Depth        = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              tile_we_i,
   input  logic [AddrWidth-1:0]              tile_addr_i,
   input  logic [OutDataWidth*M*N-1:0]       tile_wdata_i,
   output logic                              tile_ready_o,
   output logic                              mem_valid_o,
   input  logic                              mem_ready_i,
   output logic [AddrWidth-1:0]              mem_addr_o,
   output logic [OutDataWidth*BeatElems-1:0] mem_wdata_o,
   output logic                              mem_last_o,
   output logic                              busy_o,
   output logic                              overflow_o
`ifdef GEMM_WB_PERF_EN
   ,
   output logic [31:0]                       stall_cycles_o,
   output logic [31:0]                       tiles_done_o
`endif
);

   localparam int Bpt   = beats_per_tile(M, N, BeatElems);
   localparam int TileW = OutDataWidth * M * N;
   localparam int BeatW = OutDataWidth * BeatElems;
   localparam int FifoW = AddrWidth + TileW;
   localparam int BiW   = (Bpt > 1) ? $clog2(Bpt) : 1;
   localparam int CntW  = $clog2(Depth + 1);
   localparam logic [BiW-1:0]       BeatLast = BiW'(Bpt - 1);
   localparam logic [AddrWidth-1:0] BptAddr  = AddrWidth'(Bpt);

   // Reject parameter sets that cannot split a tile into whole beats.
   if ((M * N) % BeatElems != 0) begin : g_bad_beat_split
      $error("gemm_c_writeback: M*N must be a multiple of BeatElems");
   end
   if (Depth < 1) begin : g_bad_depth
      $error("gemm_c_writeback: Depth must be at least 1");
   end

   wb_state_e             state;
   logic [BiW-1:0]        beat_idx;
   logic [FifoW-1:0]      head;
   logic [AddrWidth-1:0]  head_addr;
   logic [TileW-1:0]      head_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CntW-1:0]       fifo_count;
   logic                  push_ok;
   logic                  handshake;
   logic                  last_beat;
   logic                  pop;
   logic                  more_tiles;

   gemm_tile_fifo #(
      .Width (FifoW),
      .Depth (Depth)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (tile_we_i),
      .pop    (pop),
      .wdata  ({tile_addr_i, tile_wdata_i}),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign head_addr    = head[FifoW-1 -: AddrWidth];
   assign head_data    = head[TileW-1:0];
   assign push_ok      = tile_we_i && !fifo_full;
   assign tile_ready_o = !fifo_full;
   assign busy_o       = !fifo_empty;

   // Valid comes only from the state register, never from mem_ready_i.
   assign mem_valid_o  = (state == WB_SEND);
   assign last_beat    = (beat_idx == BeatLast);
   assign mem_last_o   = mem_valid_o && last_beat;
   assign handshake    = mem_valid_o && mem_ready_i;
   assign pop          = handshake && last_beat;

   // Another tile remains after this pop if one is already queued behind the
   // head or one is being written in the same cycle.
   assign more_tiles   = (fifo_count > CntW'(1)) || push_ok;

   // Beat address wraps silently modulo 2^AddrWidth.
   assign mem_addr_o   = (head_addr * BptAddr) + AddrWidth'(beat_idx);

   // Beat mux: select the BeatElems-wide slice addressed by beat_idx.
   always_comb begin
      mem_wdata_o = '0;
      for (int b = 0; b < Bpt; b++) begin
         if (beat_idx == BiW'(b)) mem_wdata_o = head_data[b*BeatW +: BeatW];
      end
   end

   // Sequencing FSM and beat counter. Entering SEND on the push itself gives
   // valid one cycle after the tile is written; the head and beat_idx only
   // move on a handshake, which keeps the offered beat stable while stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= WB_IDLE;
         beat_idx <= '0;
      end else begin
         case (state)
            WB_IDLE: begin
               beat_idx <= '0;
               if (push_ok) state <= WB_SEND;
            end
            WB_SEND: begin
               if (handshake) begin
                  if (last_beat) begin
                     beat_idx <= '0;
                     if (!more_tiles) state <= WB_IDLE;
                  end else begin
                     beat_idx <= beat_idx + BiW'(1);
                  end
               end
            end
            default: begin
               state    <= WB_IDLE;
               beat_idx <= '0;
            end
         endcase
      end
   end

   // Sticky overflow: a write while full is lost even if the head pops this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                      overflow_o <= 1'b0;
      else if (tile_we_i && fifo_full)  overflow_o <= 1'b1;
   end

`ifdef GEMM_WB_PERF_EN
   // Performance counters: back-pressure cycles and completed tiles, both wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cycles_o <= '0;
         tiles_done_o   <= '0;
      end else begin
         if (mem_valid_o && !mem_ready_i) stall_cycles_o <= stall_cycles_o + 32'd1;
         if (pop)                         tiles_done_o   <= tiles_done_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gemm_c_writeback.sv
// Self-checking bench for gemm_c_writeback (default parameters).
module tb_gemm_c_writeback;

   localparam int AW    = 16;
   localparam int TILEW = 512;
   localparam int BEATW = 128;
   localparam int BPT   = 4;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [TILEW-1:0] data;
   } tile_t;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [BEATW-1:0] data;
      logic             last;
   } beat_t;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             tile_we_i = 1'b0;
   logic [AW-1:0]    tile_addr_i = '0;
   logic [TILEW-1:0] tile_wdata_i = '0;
   logic             tile_ready_o;
   logic             mem_valid_o;
   logic             mem_ready_i = 1'b0;
   logic [AW-1:0]    mem_addr_o;
   logic [BEATW-1:0] mem_wdata_o;
   logic             mem_last_o;
   logic             busy_o;
   logic             overflow_o;
`ifdef GEMM_WB_PERF_EN
   logic [31:0]      stall_cycles_o;
   logic [31:0]      tiles_done_o;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: queue of accepted tiles, beat position, overflow flag
   tile_t tq[$];
   int    mbeat = 0;
   logic  movf = 1'b0;
   beat_t blog[$];

   gemm_c_writeback dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .tile_we_i    (tile_we_i),
      .tile_addr_i  (tile_addr_i),
      .tile_wdata_i (tile_wdata_i),
      .tile_ready_o (tile_ready_o),
      .mem_valid_o  (mem_valid_o),
      .mem_ready_i  (mem_ready_i),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_last_o   (mem_last_o),
      .busy_o       (busy_o),
      .overflow_o   (overflow_o)
`ifdef GEMM_WB_PERF_EN
      ,
      .stall_cycles_o (stall_cycles_o),
      .tiles_done_o   (tiles_done_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TILEW-1:0] rand_tile();
      logic [TILEW-1:0] d;
      for (int i = 0; i < TILEW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // One clock: compare against the model at negedge, log handshakes, then
   // advance the model at posedge. Inputs are changed by the caller at posedge+1.
   task automatic cycle();
      logic          exp_valid;
      logic [AW-1:0] exp_addr;
      tile_t         t;
      @(negedge clk_i);
      exp_valid = (tq.size() != 0);
      chk("valid", mem_valid_o, exp_valid);
      chk("tile_ready", tile_ready_o, tq.size() < DEPTH);
      chk("busy", busy_o, exp_valid);
      chk("overflow", overflow_o, movf);
      chk("last", mem_last_o, exp_valid && (mbeat == BPT - 1));
      if (exp_valid) begin
         t = tq[0];
         exp_addr = AW'(t.addr * BPT + mbeat);
         chk("addr", mem_addr_o, exp_addr);
         chk("wdata", mem_wdata_o, t.data[mbeat*BEATW +: BEATW]);
      end
      if (mem_valid_o && mem_ready_i) blog.push_back('{mem_addr_o, mem_wdata_o, mem_last_o});
      @(posedge clk_i);
      if (tile_we_i && tq.size() >= DEPTH) movf = 1'b1;
      if (exp_valid && mem_ready_i) begin
         if (mbeat == BPT - 1) begin
            void'(tq.pop_front());
            mbeat = 0;
         end else begin
            mbeat++;
         end
      end
      if (tile_we_i && !(tq.size() >= DEPTH || (tq.size() == DEPTH - 1 && 1'b0)))
         ;
      #1;
   endtask

   // Pushes are applied in the model after the pop decision; a full FIFO
   // (judged before the pop) drops the write.
   task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [TILEW-1:0] d,
                      input logic rdy);
      int pre;
      tile_we_i    = we;
      tile_addr_i  = a;
      tile_wdata_i = d;
      mem_ready_i  = rdy;
      pre = tq.size();
      cycle();
      if (we && pre < DEPTH) tq.push_back('{a, d});
      tile_we_i = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_ni      = 1'b0;
      tile_we_i   = 1'b0;
      mem_ready_i = 1'b0;
      tq.delete();
      mbeat = 0;
      movf  = 1'b0;
      #2;
      chk("reset_valid", mem_valid_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [TILEW-1:0] seq;
      logic [BEATW-1:0] b0;
      for (int e = 0; e < 16; e++) seq[e*32 +: 32] = 32'(e + 1);

      // reset state
      do_reset();
      chk("rst_tile_ready", tile_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_last", mem_last_o, 1'b0);
      chk("rst_overflow", overflow_o, 1'b0);

      // 1: single tile, addr 3, always ready
      blog.delete();
      cyc(1'b1, 16'd3, seq, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b1);
      b0 = {32'd4, 32'd3, 32'd2, 32'd1};
      chk("s1_nbeats", blog.size(), 4);
      if (blog.size() == 4) begin
         chk("s1_beat0", blog[0].data, b0);
         for (int i = 0; i < 4; i++) chk("s1_addr", blog[i].addr, 16'(12 + i));
         chk("s1_last3", blog[3].last, 1'b1);
         chk("s1_last0", blog[0].last, 1'b0);
      end
      chk("s1_idle", mem_valid_o, 1'b0);

      // 2: same tile with ready toggling
      do_reset();
      blog.delete();
      cyc(1'b1, 16'd3, seq, 1'b1);
      for (int i = 1; i < 12; i++) cyc(1'b0, '0, '0, (i % 2) == 0);
      chk("s2_nbeats", blog.size(), 4);
      if (blog.size() == 4) begin
         chk("s2_beat0", blog[0].data, b0);
         chk("s2_addr3", blog[3].addr, 16'd15);
      end
`ifdef GEMM_WB_PERF_EN
      chk("s2_stalls", stall_cycles_o, 32'd4);
      chk("s2_tiles", tiles_done_o, 32'd1);
`endif

      // 3: three back-to-back tiles while stalled, third dropped
      do_reset();
      blog.delete();
      for (int i = 0; i < 3; i++) cyc(1'b1, AW'(i), rand_tile(), 1'b0);
      chk("s3_tile_ready", tile_ready_o, 1'b0);
      chk("s3_overflow", overflow_o, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, '0, 1'b1);
      chk("s3_nbeats", blog.size(), 8);
      if (blog.size() == 8)
         for (int i = 0; i < 8; i++) chk("s3_addr", blog[i].addr, 16'(i));

      // 4: tile every 4 cycles, gapless stream
      do_reset();
      blog.delete();
      for (int t = 0; t < 21; t++)
         cyc((t % 4 == 0) && (t < 20), AW'($urandom), rand_tile(), 1'b1);
      chk("s4_gapless", blog.size(), 20);
      chk("s4_no_overflow", overflow_o, 1'b0);

      // 5: reset after beat1 of a tile
      do_reset();
      blog.delete();
      cyc(1'b1, 16'h0042, rand_tile(), 1'b1);
      cyc(1'b0, '0, '0, 1'b1);
      cyc(1'b0, '0, '0, 1'b1);
      rst_ni = 1'b0;
      tq.delete();
      mbeat = 0;
      movf  = 1'b0;
      #1;
      chk("s5_valid_in_reset", mem_valid_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      blog.delete();
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b1);
      chk("s5_no_stale", blog.size(), 0);

      // 6: address wrap
      do_reset();
      blog.delete();
      cyc(1'b1, 16'hFFFF, rand_tile(), 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b1);
      chk("s6_nbeats", blog.size(), 4);
      if (blog.size() == 4)
         for (int i = 0; i < 4; i++) chk("s6_addr", blog[i].addr, 16'(16'hFFFC + i));

      // random soak
      do_reset();
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 2) == 0, AW'($urandom), rand_tile(), $urandom_range(0, 1) == 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
